wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter driving the single write port of the register file. Merges results from the single-cycle ALU and the multi-cycle memory/load path, buffers memory results in a small FIFO, and emits at most one register write per cycle through a registered write port. Also reports read-after-write hazards for the two decode-stage read indices so issue logic can stall.

## Interface
- DATA_W, 32, width of register data
- IDX_W, 5, register index width; 2^IDX_W registers
- DEPTH, 4, memory-result FIFO entries; must be a power of two, at least 2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle
- alu_ready  out  1  ALU result accepted this cycle
- alu_idx  in  IDX_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  memory result present
- mem_ready  out  1  FIFO can accept a memory result
- mem_idx  in  IDX_W  memory destination register
- mem_data  in  DATA_W  memory result
- wr_en  out  1  register-file write enable (registered)
- wr_reg_index  out  IDX_W  register-file write index (registered)
- wr_reg_data  out  DATA_W  register-file write data (registered)
- rd_reg_index_1  in  IDX_W  decode read index 1
- rd_reg_index_2  in  IDX_W  decode read index 2
- hazard_1  out  1  a pending write targets rd_reg_index_1
- hazard_2  out  1  a pending write targets rd_reg_index_2

## Operation
- FIFO: DEPTH entries {idx, data}, pointers of log2(DEPTH) bits that wrap modulo DEPTH, count of log2(DEPTH)+1 bits.
- mem_ready = (count != DEPTH). Push when mem_valid && mem_ready.
- Per-cycle selection, in priority order:
  - FIFO full: pop FIFO head into output stage; alu_ready = 0.
  - Else alu_valid: ALU result into output stage; alu_ready = 1.
  - Else FIFO non-empty: pop head into output stage.
  - Else nothing selected; wr_en = 0 next cycle.
- alu_ready = (count != DEPTH), combinational from registered count; independent of alu_valid.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- A selected entry with index 0 is consumed (popped or acknowledged) but loads wr_en = 0. Register 0 is never written.
- No ordering between sources is enforced. Write-after-write ordering across sources is the responsibility of issue logic via hazard_*.
- hazard_n = (rd_reg_index_n != 0) && (idx matches any valid FIFO entry, or wr_en && wr_reg_index matches). Combinational.

## Timing
- Reset (rst low, asynchronous): wr_en = 0, wr_reg_index = 0, wr_reg_data = 0, FIFO empty, pointers 0. Outputs are immediately mem_ready = 1, alu_ready = 1, hazard_1 = hazard_2 = 0. Reset mid-operation discards all buffered results.
- ALU latency: accepted at edge N → wr_en/index/data valid in the cycle after edge N (1 cycle).
- Memory latency, minimum 2: pushed at edge N, popped at edge N+1 if no ALU result competes, write visible after edge N+1.
- Throughput: one write per cycle. FIFO fills when ALU results arrive every cycle; once full, one FIFO entry drains per cycle while alu_ready is low.
- Full boundary: count == DEPTH means no push and a forced pop, so the next cycle has count = DEPTH-1 and mem_ready = 1.

## Test plan
- Reset: hold rst low 3 cycles with valid inputs active → wr_en = 0, mem_ready = 1, alu_ready = 1, hazards 0. Release rst → first ALU write {idx 5, 0xA5A5A5A5} appears 1 cycle later.
- Basic writes: ALU {3, 0x11} at edge 1 → wr_en at cycle 2. MEM {7, 0x22} at edge 3 with idle ALU → write {7, 0x22} after edge 4.
- Contention: push MEM {4, 0x44} while ALU sends {6, 0x66} every cycle for 6 cycles. Require FIFO fill to DEPTH, alu_ready low exactly on full cycles, every value written exactly once, and mem_ready deasserted only when count == 4.
- Register 0: ALU {0, 0xFF} and MEM {0, 0xEE} → both consumed, wr_en never asserted, hazard_n = 0 for rd index 0.
- Hazards: MEM {9, x} buffered behind ALU traffic, rd_reg_index_1 = 9 → hazard_1 = 1 until the cycle after the write drains. rd_reg_index_2 = 10 → hazard_2 = 0.
- Wrap-around: push 3×DEPTH memory results with no ALU traffic → all written in push order, pointers wrap, count returns to 0.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter for the single register-file write port.
//   Merges single-cycle ALU results with multi-cycle memory results.
//   Memory results are buffered in a DEPTH-entry FIFO. At most one
//   register write is issued per cycle through a registered write port.
//   Read-after-write hazards are reported for two decode read indices.
//
// Ports:
//   clk                          clock, rising edge
//   rst                          asynchronous active-low reset
//   alu_valid/alu_idx/alu_data   ALU result in
//   alu_ready                    ALU result accepted this cycle
//   mem_valid/mem_idx/mem_data   memory result in
//   mem_ready                    FIFO can accept a memory result
//   wr_en/wr_reg_index/wr_reg_data  registered register-file write port
//   rd_reg_index_1/2             decode-stage read indices
//   hazard_1/2                   a pending write targets the read index
module wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [IDX_W-1:0]  alu_idx,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [IDX_W-1:0]  mem_idx,
    input  logic [DATA_W-1:0] mem_data,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_reg_index,
    output logic [DATA_W-1:0] wr_reg_data,
    input  logic [IDX_W-1:0]  rd_reg_index_1,
    input  logic [IDX_W-1:0]  rd_reg_index_2,
    output logic              hazard_1,
    output logic              hazard_2
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [IDX_W-1:0]  fifo_idx  [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W:0]    count;

    logic              full;
    logic              push;
    logic              pop;
    logic              sel_valid;
    logic [IDX_W-1:0]  sel_idx;
    logic [DATA_W-1:0] sel_data;
    logic [DEPTH-1:0]  entry_valid;

    assign full      = (count == FULL_CNT);
    assign mem_ready = !full;
    assign alu_ready = !full;
    assign push      = mem_valid && !full;

    // A full FIFO always wins so it cannot stall the memory path forever;
    // otherwise the ALU has priority over buffered memory results.
    always_comb begin
        pop       = 1'b0;
        sel_valid = 1'b0;
        sel_idx   = fifo_idx[rptr];
        sel_data  = fifo_data[rptr];
        if (full) begin
            pop       = 1'b1;
            sel_valid = 1'b1;
        end else if (alu_valid) begin
            sel_valid = 1'b1;
            sel_idx   = alu_idx;
            sel_data  = alu_data;
        end else if (count != '0) begin
            pop       = 1'b1;
            sel_valid = 1'b1;
        end
    end

    // FIFO storage needs no reset: validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wptr]  <= mem_idx;
            fifo_data[wptr] <= mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            wr_en        <= 1'b0;
            wr_reg_index <= '0;
            wr_reg_data  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Index-0 results are consumed but never written.
            wr_en <= sel_valid && (sel_idx != '0);
            if (sel_valid) begin
                wr_reg_index <= sel_idx;
                wr_reg_data  <= sel_data;
            end
        end
    end

    // Entry i is live when its distance from the read pointer is below count.
    always_comb begin
        entry_valid = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] offset;
            offset = PTR_W'(i) - rptr;
            entry_valid[i] = ({1'b0, offset} < count);
        end
    end

    function automatic logic pending_write(input logic [IDX_W-1:0] rd);
        logic hit;
        hit = wr_en && (wr_reg_index == rd);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (fifo_idx[i] == rd)) hit = 1'b1;
        end
        return (rd != '0) && hit;
    endfunction

    assign hazard_1 = pending_write(rd_reg_index_1);
    assign hazard_2 = pending_write(rd_reg_index_2);

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_idx;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_idx;
    logic [31:0] mem_data;
    logic        wr_en;
    logic [4:0]  wr_reg_index;
    logic [31:0] wr_reg_data;
    logic [4:0]  rd_reg_index_1;
    logic [4:0]  rd_reg_index_2;
    logic        hazard_1;
    logic        hazard_2;

    wb_arbiter #(.DATA_W(32), .IDX_W(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_idx(alu_idx), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_idx(mem_idx), .mem_data(mem_data),
        .wr_en(wr_en), .wr_reg_index(wr_reg_index), .wr_reg_data(wr_reg_data),
        .rd_reg_index_1(rd_reg_index_1), .rd_reg_index_2(rd_reg_index_2),
        .hazard_1(hazard_1), .hazard_2(hazard_2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: buffered memory results as a queue, plus the
    // write that should currently be on the register-file port.
    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic        exp_en;
    logic [4:0]  exp_idx;
    logic [31:0] exp_data;
    logic        alu_acc;
    logic        mem_acc;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_hazard(input logic [4:0] rd);
        logic hit;
        hit = exp_en && (exp_idx == rd);
        foreach (q[i]) if (q[i].idx == rd) hit = 1'b1;
        return (rd != 5'd0) && hit;
    endfunction

    task automatic model_reset();
        q.delete();
        exp_en   = 1'b0;
        exp_idx  = '0;
        exp_data = '0;
    endtask

    // Drive one cycle of inputs, check all outputs, then step the model
    // across the next rising edge.
    task automatic cycle(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mi, input logic [31:0] md,
                         input logic [4:0] r1, input logic [4:0] r2);
        logic        full;
        logic        take;
        ent_t        sel;
        alu_valid = av; alu_idx = ai; alu_data = ad;
        mem_valid = mv; mem_idx = mi; mem_data = md;
        rd_reg_index_1 = r1; rd_reg_index_2 = r2;
        #1;
        full = (q.size() == DEPTH);
        chk("alu_ready", alu_ready, !full);
        chk("mem_ready", mem_ready, !full);
        chk("hazard_1", hazard_1, model_hazard(r1));
        chk("hazard_2", hazard_2, model_hazard(r2));
        chk("wr_en", wr_en, exp_en);
        if (exp_en) begin
            chk("wr_reg_index", wr_reg_index, exp_idx);
            chk("wr_reg_data", wr_reg_data, exp_data);
        end
        alu_acc = av && !full;
        mem_acc = mv && !full;
        take = 1'b0;
        sel.idx = '0;
        sel.data = '0;
        if (full || (!av && q.size() != 0)) begin
            sel = q.pop_front();
            take = 1'b1;
        end else if (av) begin
            sel.idx = ai;
            sel.data = ad;
            take = 1'b1;
        end
        if (mem_acc) q.push_back('{mi, md});
        @(posedge clk);
        #1;
        exp_en = take && (sel.idx != 5'd0);
        if (exp_en) begin
            exp_idx  = sel.idx;
            exp_data = sel.data;
        end
    endtask

    task automatic idle(input int n, input logic [4:0] r1, input logic [4:0] r2);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    initial begin
        logic        pa_v, pm_v;
        logic [4:0]  pa_i, pm_i;
        logic [31:0] pa_d, pm_d;
        int          seen_full;

        // Reset held with valid inputs active.
        rst = 1'b0;
        alu_valid = 1; alu_idx = 5; alu_data = 32'hA5A5A5A5;
        mem_valid = 1; mem_idx = 6; mem_data = 32'h12345678;
        rd_reg_index_1 = 5; rd_reg_index_2 = 6;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_wr_en", wr_en, 1'b0);
            chk("rst_wr_idx", wr_reg_index, 5'd0);
            chk("rst_wr_data", wr_reg_data, 32'd0);
            chk("rst_mem_ready", mem_ready, 1'b1);
            chk("rst_alu_ready", alu_ready, 1'b1);
            chk("rst_hazard_1", hazard_1, 1'b0);
            chk("rst_hazard_2", hazard_2, 1'b0);
        end
        rst = 1'b1;
        cycle(1, 5, 32'hA5A5A5A5, 0, 0, 0, 5, 0);
        chk("first_write_en", wr_en, 1'b1);
        chk("first_write_data", wr_reg_data, 32'hA5A5A5A5);
        idle(1, 0, 0);

        // Basic ALU then memory write.
        cycle(1, 3, 32'h11, 0, 0, 0, 3, 7);
        cycle(0, 0, 0, 1, 7, 32'h22, 3, 7);
        cycle(0, 0, 0, 0, 0, 0, 3, 7);
        chk("mem_write_latency_en", wr_en, 1'b1);
        chk("mem_write_latency_idx", wr_reg_index, 5'd7);
        idle(2, 7, 3);

        // Contention: ALU every cycle, memory every cycle; FIFO fills.
        seen_full = 0;
        for (int i = 0; i < 6; i++) begin
            if (q.size() == DEPTH) seen_full++;
            cycle(1, 6, 32'h66 + i, 1, 4, 32'h44 + i, 4, 6);
        end
        for (int i = 0; i < 3; i++) begin
            if (q.size() == DEPTH) seen_full++;
            cycle(1, 6, 32'h70 + i, 0, 0, 0, 4, 6);
        end
        chk("contention_reached_full", (seen_full > 0), 1'b1);
        idle(DEPTH + 2, 4, 6);
        chk("contention_drained", q.size(), 0);

        // Register 0 from both sources.
        cycle(1, 0, 32'hFF, 1, 0, 32'hEE, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        chk("reg0_alu_no_write", wr_en, 1'b0);
        idle(2, 0, 0);

        // Hazard on a buffered memory result behind ALU traffic.
        cycle(1, 1, 32'h100, 1, 9, 32'h99, 9, 10);
        for (int i = 0; i < 3; i++) cycle(1, 2, 32'h200 + i, 0, 0, 0, 9, 10);
        idle(3, 9, 10);
        chk("hazard_cleared", hazard_1, 1'b0);

        // Wrap-around: 3*DEPTH memory results, no ALU traffic.
        for (int i = 0; i < 3 * DEPTH; i++)
            cycle(0, 0, 0, 1, 5'(i + 1), 32'hC000 + i, 5'(i + 1), 5'(i));
        idle(3, 5'(3 * DEPTH), 1);
        chk("wrap_empty_mem_ready", mem_ready, 1'b1);
        chk("wrap_model_empty", q.size(), 0);

        // Random traffic with hold-until-accepted sources.
        pa_v = 0; pm_v = 0; pa_i = 0; pm_i = 0; pa_d = 0; pm_d = 0;
        for (int i = 0; i < 300; i++) begin
            if (!pa_v && $urandom_range(0, 3) != 0) begin
                pa_v = 1; pa_i = 5'($urandom_range(0, 7)); pa_d = $urandom;
            end
            if (!pm_v && $urandom_range(0, 2) != 0) begin
                pm_v = 1; pm_i = 5'($urandom_range(0, 7)); pm_d = $urandom;
            end
            cycle(pa_v, pa_i, pa_d, pm_v, pm_i, pm_d,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if (alu_acc) pa_v = 0;
            if (mem_acc) pm_v = 0;
        end
        idle(DEPTH + 2, 0, 0);

        // Asynchronous reset mid-operation discards buffered results.
        for (int i = 0; i < 3; i++) cycle(1, 3, 32'h300 + i, 1, 12, 32'h1200 + i, 12, 3);
        alu_valid = 0; mem_valid = 0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_wr_en", wr_en, 1'b0);
        chk("async_rst_wr_idx", wr_reg_index, 5'd0);
        chk("async_rst_mem_ready", mem_ready, 1'b1);
        chk("async_rst_alu_ready", alu_ready, 1'b1);
        chk("async_rst_hazard_1", hazard_1, 1'b0);
        chk("async_rst_hazard_2", hazard_2, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(3, 12, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
